pio_strobe_sequencer: RTL and testbench
=======================================

Name: pio_strobe_sequencer

Overview:
Parametrised, clocked successor to the combinational PIO chip-select decoder. Decodes a main/sub address window, then sequences a one-hot device strobe through setup, active and hold phases with per-main-window wait states. Returns a dtack handshake to the host bus. Sits between the CPU bus interface and the PIO peripherals: POST/output latches, UART, PIT, PCF, USB FIFO and interrupt controller.

Parameters:
MAIN_BITS, 3, width of main window select (adm field); NMAIN = 2**MAIN_BITS
SUB_BITS, 2, width of sub window select (adl field); NSUB = 2**SUB_BITS
CNT_W, 4, width of phase counters
SETUP_CYC, 1, cycles strobe held low after decode before asserting (0 = skip phase)
HOLD_CYC, 1, cycles after strobe deasserts before dtack (0 = skip phase)
WAIT_TABLE, all 0, NMAIN*CNT_W bits; field m = extra active cycles for main window m (active length = field+1)
MAP_MASK, all 1, NMAIN*NSUB bits; bit i = 1 marks window i as populated

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cs  in  1  PIO region select from bus decode, sampled on clk
rw_n  in  1  1 = read, 0 = write
adm  in  MAIN_BITS  main window select
adl  in  SUB_BITS  sub window select
strobe  out  NMAIN*NSUB  one-hot device strobe, index = main*NSUB + sub, active-high
rd_en  out  1  high while strobe is active and the latched rw_n = 1
wr_en  out  1  high while strobe is active and the latched rw_n = 0
dtack  out  1  access complete, active-high
busy  out  1  high in any state other than IDLE
berr  out  1  bus error; only with PIO_BERR_EN, otherwise tied 0

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high. The clock port is clk and the reset port is reset. All outputs are registered.
- Reset: state = IDLE; strobe = 0, rd_en = wr_en = dtack = busy = berr = 0; counters = 0. Reset asserted mid-access aborts the access immediately: strobes fall on the next edge and no dtack is issued.
- States: IDLE, SETUP, ACTIVE, HOLD, ACK.
- IDLE, cs = 1:
  - Latch idx = {adm, adl} and rw_n.
  - Load the counter.
  - Go to SETUP, or straight to ACTIVE if SETUP_CYC = 0.
  - Address and rw_n changes after this latch are ignored until the next IDLE.
- SETUP: strobe = 0 for exactly SETUP_CYC cycles, then ACTIVE.
- ACTIVE:
  - strobe[idx] = 1 and rd_en/wr_en = 1 (per latched rw_n) for exactly WAIT_TABLE[main]+1 cycles.
  - Then HOLD, or ACK if HOLD_CYC = 0.
- HOLD: strobe = 0 for exactly HOLD_CYC cycles, then ACK.
- ACK: dtack = 1. Remain in ACK until cs is sampled 0, then IDLE with dtack = 0 on that same edge.
- Back-to-back accesses: a new access requires cs to be sampled 0 at least once. cs held high after ACK does not retrigger.
- Latency, with cs sampled high at edge 0:
  - Strobe first high after edge 1+SETUP_CYC.
  - dtack first high after edge 1+SETUP_CYC+(WAIT_TABLE[m]+1)+HOLD_CYC.
- Abort: cs sampled 0 in SETUP, ACTIVE or HOLD returns to IDLE on that edge. Strobes drop and dtack stays 0.
- Strobe is strictly one-hot or zero. Never more than one bit is set, and no bit is set outside ACTIVE.
- A WAIT_TABLE field at its maximum value (2**CNT_W-1) gives 2**CNT_W active cycles with no counter wrap.
- Default-parameter map, per main window:
  - m0 sub0..3 = POST/OUTP/PIO2 latches and SPI
  - m1 = UART, PIT, PCF, overlay
  - m2 = USB
  - m3 = interrupt controller
  - Downstream qualifies write-only devices with wr_en.

Optional Feature:
PIO_BERR_EN:
- Enabled:
  - An access whose idx has MAP_MASK[idx] = 0 goes IDLE -> ACK with no strobe.
  - In ACK it asserts berr = 1 instead of dtack.
  - berr clears when cs is sampled 0.
- Disabled:
  - berr is tied 0.
  - Unmapped windows run the normal sequence, with the strobe on the unmapped index.

Test Plan:
1. Defaults, write adm = 0 adl = 1:
   - strobe[1] and wr_en high for 1 cycle, starting 2 cycles after cs is sampled.
   - dtack high 4 cycles after cs is sampled; dtack drops the cycle cs is sampled low.
2. WAIT_TABLE[2] = 5, read adm = 2 adl = 3: strobe[11] and rd_en high for exactly 6 cycles; wr_en stays 0.
3. SETUP_CYC = HOLD_CYC = 0, adm = 1 adl = 0: strobe[4] high the cycle after cs is sampled; dtack high the following cycle.
4. Abort: WAIT_TABLE[3] = 7, cs dropped on the 3rd ACTIVE cycle -> strobe = 0 next edge, dtack never asserted, busy = 0.
5. cs held high 20 cycles after dtack -> exactly one strobe pulse. After cs low for 1 cycle and high again -> second pulse.
6. PIO_BERR_EN with MAP_MASK[30] = 0, adm = 7 adl = 2:
   - No strobe; berr = 1 the cycle after cs is sampled; dtack = 0.
   - Reset asserted during ACK clears berr on the next edge.

Source files
------------

// File: rtl/pio_strobe_sequencer.sv
// rtl/pio_strobe_sequencer.sv - PIO window decode and strobe sequencer
// Optional bus-error response for unmapped windows: PIO_BERR_EN
module pio_strobe_sequencer #(
    parameter int MAIN_BITS = 3,
    parameter int SUB_BITS  = 2,
    parameter int CNT_W     = 4,
    parameter int SETUP_CYC = 1,
    parameter int HOLD_CYC  = 1,
    parameter logic [(2**MAIN_BITS)*CNT_W-1:0]          WAIT_TABLE = '0,
    parameter logic [(2**MAIN_BITS)*(2**SUB_BITS)-1:0]  MAP_MASK   = '1
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        cs,
    input  logic                                        rw_n,
    input  logic [MAIN_BITS-1:0]                        adm,
    input  logic [SUB_BITS-1:0]                         adl,
    output logic [(2**MAIN_BITS)*(2**SUB_BITS)-1:0]     strobe,
    output logic                                        rd_en,
    output logic                                        wr_en,
    output logic                                        dtack,
    output logic                                        busy,
    output logic                                        berr
);

    localparam int NMAIN = 2**MAIN_BITS;
    localparam int NSUB  = 2**SUB_BITS;
    localparam int NDEV  = NMAIN * NSUB;
    localparam int IDX_W = MAIN_BITS + SUB_BITS;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_ACTIVE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_ACK    = 3'd4;

    localparam logic [CNT_W-1:0] SETUP_LOAD = (SETUP_CYC > 0) ? CNT_W'(SETUP_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] HOLD_LOAD  = (HOLD_CYC > 0)  ? CNT_W'(HOLD_CYC - 1)  : '0;

    logic [2:0]           state;
    logic [2:0]           next_state;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     next_cnt;
    logic [IDX_W-1:0]     idx_l;
    logic                 rd_l;
    logic                 err_l;
    logic                 start;
    logic                 map_miss;
    logic [IDX_W-1:0]     idx_in;
    logic [CNT_W-1:0]     wait_in;
    logic [CNT_W-1:0]     wait_l;
    logic [NDEV-1:0]      dev_onehot;

    assign idx_in     = {adm, adl};
    assign wait_in    = WAIT_TABLE[int'(adm) * CNT_W +: CNT_W];
    assign wait_l     = WAIT_TABLE[int'(idx_l[IDX_W-1:SUB_BITS]) * CNT_W +: CNT_W];
    assign dev_onehot = NDEV'(1) << idx_l;

`ifdef PIO_BERR_EN
    assign map_miss = ~MAP_MASK[idx_in];
`else
    logic unused_map;
    assign unused_map = MAP_MASK[idx_in];
    assign map_miss   = 1'b0;
`endif

    // Phase counters count down to zero; a loaded value n gives n+1 cycles
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        start      = 1'b0;
        case (state)
            S_IDLE: begin
                if (cs) begin
                    start = 1'b1;
                    if (map_miss) begin
                        next_state = S_ACK;
                        next_cnt   = '0;
                    end else if (SETUP_CYC > 0) begin
                        next_state = S_SETUP;
                        next_cnt   = SETUP_LOAD;
                    end else begin
                        next_state = S_ACTIVE;
                        next_cnt   = wait_in;
                    end
                end
            end
            S_SETUP: begin
                if (!cs) begin
                    next_state = S_IDLE;
                    next_cnt   = '0;
                end else if (cnt == '0) begin
                    next_state = S_ACTIVE;
                    next_cnt   = wait_l;
                end else begin
                    next_cnt = cnt - 1'b1;
                end
            end
            S_ACTIVE: begin
                if (!cs) begin
                    next_state = S_IDLE;
                    next_cnt   = '0;
                end else if (cnt == '0) begin
                    next_state = (HOLD_CYC > 0) ? S_HOLD : S_ACK;
                    next_cnt   = HOLD_LOAD;
                end else begin
                    next_cnt = cnt - 1'b1;
                end
            end
            S_HOLD: begin
                if (!cs) begin
                    next_state = S_IDLE;
                    next_cnt   = '0;
                end else if (cnt == '0) begin
                    next_state = S_ACK;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt - 1'b1;
                end
            end
            S_ACK: begin
                if (!cs) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    // Outputs follow the state by one cycle; gating with cs makes aborts and
    // the ACK release drop strobe/dtack on the very edge cs is seen low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            idx_l  <= '0;
            rd_l   <= 1'b0;
            err_l  <= 1'b0;
            strobe <= '0;
            rd_en  <= 1'b0;
            wr_en  <= 1'b0;
            dtack  <= 1'b0;
            busy   <= 1'b0;
            berr   <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (start) begin
                idx_l <= idx_in;
                rd_l  <= rw_n;
                err_l <= map_miss;
            end
            strobe <= (state == S_ACTIVE && cs) ? dev_onehot : '0;
            rd_en  <= (state == S_ACTIVE) && cs && rd_l;
            wr_en  <= (state == S_ACTIVE) && cs && !rd_l;
            dtack  <= (state == S_ACK) && cs && !err_l;
            busy   <= (next_state != S_IDLE);
`ifdef PIO_BERR_EN
            berr   <= (state == S_ACK) && cs && err_l;
`else
            berr   <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_pio_strobe_sequencer.sv
// tb/tb_pio_strobe_sequencer.sv - randomized self-checking bench for pio_strobe_sequencer
module tb_pio_strobe_sequencer;

    localparam logic [31:0] WT_A   = 32'h00F0_7500;
    localparam logic [31:0] MASK_A = 32'hBFFF_FFFF;
    localparam logic [31:0] WT_B   = 32'h0000_3000;
`ifdef PIO_BERR_EN
    localparam bit BERR_EN = 1'b1;
`else
    localparam bit BERR_EN = 1'b0;
`endif

    int wt_a [8] = '{0, 0, 5, 7, 0, 15, 0, 0};
    int wt_b [8] = '{0, 0, 0, 3, 0, 0, 0, 0};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cs_a = 1'b0, rw_n_a = 1'b0, cs_b = 1'b0, rw_n_b = 1'b0;
    logic [2:0] adm_a = '0, adm_b = '0;
    logic [1:0] adl_a = '0, adl_b = '0;
    logic [31:0] strobe_a, strobe_b;
    logic rd_en_a, wr_en_a, dtack_a, busy_a, berr_a;
    logic rd_en_b, wr_en_b, dtack_b, busy_b, berr_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pio_strobe_sequencer #(.SETUP_CYC(1), .HOLD_CYC(1), .WAIT_TABLE(WT_A), .MAP_MASK(MASK_A)) dut_a (
        .clk(clk), .reset(reset), .cs(cs_a), .rw_n(rw_n_a), .adm(adm_a), .adl(adl_a),
        .strobe(strobe_a), .rd_en(rd_en_a), .wr_en(wr_en_a), .dtack(dtack_a), .busy(busy_a), .berr(berr_a));

    pio_strobe_sequencer #(.SETUP_CYC(0), .HOLD_CYC(0), .WAIT_TABLE(WT_B)) dut_b (
        .clk(clk), .reset(reset), .cs(cs_b), .rw_n(rw_n_b), .adm(adm_b), .adl(adl_b),
        .strobe(strobe_b), .rd_en(rd_en_b), .wr_en(wr_en_b), .dtack(dtack_b), .busy(busy_b), .berr(berr_b));

    // Reference: timing from the sample edge of cs, expressed as cycle offsets.
    task automatic model(input bit b, input int m, input int s,
                         output int sf, output int len, output int dt, output int be);
        int setup, hold, act;
        bit err;
        setup = b ? 0 : 1;
        hold  = b ? 0 : 1;
        act   = (b ? wt_b[m] : wt_a[m]) + 1;
        err   = BERR_EN && !b && (m * 4 + s == 30);
        sf  = err ? -1 : 1 + setup;
        len = err ? 0 : act;
        dt  = err ? -1 : 1 + setup + act + hold;
        be  = err ? 1 : -1;
    endtask

    task automatic set_cs(input bit b, input logic v);
        if (b) cs_b = v; else cs_a = v;
    endtask

    task automatic access(input bit b, input int m, input int s, input bit rd,
                          input int abort_at, input bit release_cs,
                          output int st_first, output int st_len, output int dt_first,
                          output int be_first, output int bad,
                          output logic [31:0] l_strobe, output logic l_busy,
                          output logic l_dtack, output logic l_berr);
        logic [31:0] stb, hot;
        logic r, w, dt, be, bz;
        bit done;
        hot = 32'd1 << (m * 4 + s);
        st_first = -1; st_len = 0; dt_first = -1; be_first = -1; bad = 0; done = 0;
        @(negedge clk);
        if (b) begin adm_b = 3'(m); adl_b = 2'(s); rw_n_b = rd; end
        else   begin adm_a = 3'(m); adl_a = 2'(s); rw_n_a = rd; end
        set_cs(b, 1'b1);
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            stb = b ? strobe_b : strobe_a;
            r   = b ? rd_en_b : rd_en_a;
            w   = b ? wr_en_b : wr_en_a;
            dt  = b ? dtack_b : dtack_a;
            be  = b ? berr_b : berr_a;
            bz  = b ? busy_b : busy_a;
            if (k == 0) begin
                if (b) begin adm_b = 3'($urandom); adl_b = 2'($urandom); rw_n_b = 1'($urandom); end
                else   begin adm_a = 3'($urandom); adl_a = 2'($urandom); rw_n_a = 1'($urandom); end
            end
            if (stb != '0) begin
                if (st_first < 0) st_first = k;
                st_len++;
                if (stb !== hot) bad++;
            end
            if (r !== ((stb != '0) && rd) || w !== ((stb != '0) && !rd)) bad++;
            if (dt === 1'b1 && dt_first < 0) dt_first = k;
            if (be === 1'b1 && be_first < 0) be_first = k;
            l_strobe = stb; l_busy = bz; l_dtack = dt; l_berr = be;
            if (abort_at > 0 && st_len == abort_at) begin
                set_cs(b, 1'b0);
                @(negedge clk);
                done = 1;
            end else if (dt === 1'b1 || be === 1'b1) begin
                done = 1;
                if (release_cs) begin
                    set_cs(b, 1'b0);
                    @(negedge clk);
                end
            end
            if (done && (abort_at > 0 || release_cs)) begin
                l_strobe = b ? strobe_b : strobe_a;
                l_busy   = b ? busy_b : busy_a;
                l_dtack  = b ? dtack_b : dtack_a;
                l_berr   = b ? berr_b : berr_a;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({strobe_a, rd_en_a, wr_en_a, dtack_a, busy_a, berr_a} !== '0) begin
            errors++; $display("FAIL reset_a: got %h want 0", {strobe_a, rd_en_a, wr_en_a, dtack_a, busy_a, berr_a});
        end
        checks++;
        if ({strobe_b, rd_en_b, wr_en_b, dtack_b, busy_b, berr_b} !== '0) begin
            errors++; $display("FAIL reset_b: got %h want 0", {strobe_b, rd_en_b, wr_en_b, dtack_b, busy_b, berr_b});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || dtack_a !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: busy %b dtack %b want 0 0", busy_a, dtack_a);
        end
    endtask

    task automatic test_default_write;
        int sf, len, dt, be, bad, esf, elen, edt, ebe;
        logic [31:0] ls; logic lb, ld, le;
        model(0, 0, 1, esf, elen, edt, ebe);
        access(0, 0, 1, 1'b0, 0, 1'b1, sf, len, dt, be, bad, ls, lb, ld, le);
        checks++; if (sf !== esf) begin errors++; $display("FAIL wr_strobe_first: got %0d want %0d", sf, esf); end
        checks++; if (len !== elen) begin errors++; $display("FAIL wr_strobe_len: got %0d want %0d", len, elen); end
        checks++; if (dt !== edt) begin errors++; $display("FAIL wr_dtack_first: got %0d want %0d", dt, edt); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL wr_onehot_en: got %0d bad samples want 0", bad); end
        checks++; if (ld !== 1'b0 || lb !== 1'b0) begin errors++; $display("FAIL wr_release: dtack %b busy %b want 0 0", ld, lb); end
    endtask

    task automatic test_wait_read;
        int sf, len, dt, be, bad, esf, elen, edt, ebe;
        logic [31:0] ls; logic lb, ld, le;
        model(0, 2, 3, esf, elen, edt, ebe);
        access(0, 2, 3, 1'b1, 0, 1'b1, sf, len, dt, be, bad, ls, lb, ld, le);
        checks++; if (len !== elen) begin errors++; $display("FAIL rd_wait_len: got %0d want %0d", len, elen); end
        checks++; if (dt !== edt) begin errors++; $display("FAIL rd_dtack_first: got %0d want %0d", dt, edt); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rd_onehot_en: got %0d bad samples want 0", bad); end
    endtask

    task automatic test_zero_phase;
        int sf, len, dt, be, bad, esf, elen, edt, ebe;
        logic [31:0] ls; logic lb, ld, le;
        model(1, 1, 0, esf, elen, edt, ebe);
        access(1, 1, 0, 1'b0, 0, 1'b1, sf, len, dt, be, bad, ls, lb, ld, le);
        checks++; if (sf !== esf) begin errors++; $display("FAIL zp_strobe_first: got %0d want %0d", sf, esf); end
        checks++; if (dt !== edt) begin errors++; $display("FAIL zp_dtack_first: got %0d want %0d", dt, edt); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL zp_onehot: got %0d bad samples want 0", bad); end
    endtask

    task automatic test_max_wait;
        int sf, len, dt, be, bad, esf, elen, edt, ebe;
        logic [31:0] ls; logic lb, ld, le;
        model(0, 5, 2, esf, elen, edt, ebe);
        access(0, 5, 2, 1'b1, 0, 1'b1, sf, len, dt, be, bad, ls, lb, ld, le);
        checks++; if (len !== elen) begin errors++; $display("FAIL max_wait_len: got %0d want %0d", len, elen); end
        checks++; if (dt !== edt) begin errors++; $display("FAIL max_wait_dtack: got %0d want %0d", dt, edt); end
    endtask

    task automatic test_abort;
        int sf, len, dt, be, bad, seen;
        logic [31:0] ls; logic lb, ld, le;
        access(0, 3, 0, 1'b0, 3, 1'b0, sf, len, dt, be, bad, ls, lb, ld, le);
        checks++; if (ls !== '0) begin errors++; $display("FAIL abort_strobe: got %h want 0", ls); end
        checks++; if (lb !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", lb); end
        seen = (dt >= 0) ? 1 : 0;
        repeat (12) begin
            @(negedge clk);
            if (dtack_a === 1'b1 || strobe_a !== '0) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_dtack: got %0d events want 0", seen); end
    endtask

    task automatic test_back_to_back;
        int sf, len, dt, be, bad, extra, second;
        logic [31:0] ls; logic lb, ld, le;
        access(0, 0, 0, 1'b0, 0, 1'b0, sf, len, dt, be, bad, ls, lb, ld, le);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (strobe_a !== '0) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_no_retrigger: got %0d strobe cycles want 0", extra); end
        checks++; if (dtack_a !== 1'b1) begin errors++; $display("FAIL b2b_dtack_held: got %b want 1", dtack_a); end
        cs_a = 1'b0; adm_a = 3'd0; adl_a = 2'd0; rw_n_a = 1'b0;
        @(negedge clk);
        cs_a = 1'b1;
        second = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (strobe_a === 32'd1) second++;
        end
        checks++; if (second !== wt_a[0] + 1) begin errors++; $display("FAIL b2b_second_pulse: got %0d want %0d", second, wt_a[0] + 1); end
        cs_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_berr;
        int sf, len, dt, be, bad, esf, elen, edt, ebe;
        logic [31:0] ls; logic lb, ld, le;
        model(0, 7, 2, esf, elen, edt, ebe);
        access(0, 7, 2, 1'b1, 0, 1'b0, sf, len, dt, be, bad, ls, lb, ld, le);
        checks++; if (be !== ebe) begin errors++; $display("FAIL berr_first: got %0d want %0d", be, ebe); end
        checks++; if (len !== elen) begin errors++; $display("FAIL berr_strobe_len: got %0d want %0d", len, elen); end
        checks++; if (dt !== edt) begin errors++; $display("FAIL berr_dtack_first: got %0d want %0d", dt, edt); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (berr_a !== 1'b0 || dtack_a !== 1'b0) begin errors++; $display("FAIL berr_reset: berr %b dtack %b want 0 0", berr_a, dtack_a); end
        cs_a = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random;
        int sf, len, dt, be, bad, esf, elen, edt, ebe, m, s;
        bit b, rd;
        logic [31:0] ls; logic lb, ld, le;
        for (int i = 0; i < 12; i++) begin
            b  = 1'($urandom);
            m  = int'($urandom_range(0, 7));
            s  = int'($urandom_range(0, 3));
            rd = 1'($urandom);
            model(b, m, s, esf, elen, edt, ebe);
            access(b, m, s, rd, 0, 1'b1, sf, len, dt, be, bad, ls, lb, ld, le);
            checks++;
            if (sf !== esf || len !== elen || dt !== edt || be !== ebe || bad !== 0) begin
                errors++;
                $display("FAIL rand_%0d (b%0d m%0d s%0d): got sf %0d len %0d dt %0d be %0d bad %0d want %0d %0d %0d %0d 0",
                         i, b, m, s, sf, len, dt, be, bad, esf, elen, edt, ebe);
            end
            checks++;
            if (ld !== 1'b0 || le !== 1'b0 || lb !== 1'b0) begin
                errors++; $display("FAIL rand_release_%0d: dtack %b berr %b busy %b want 0 0 0", i, ld, le, lb);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_write();
        test_wait_read();
        test_zero_phase();
        test_max_wait();
        test_abort();
        test_back_to_back();
        test_berr();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
